// File: rtl/rsfq_jtl_pipe_if.sv
// Pulse-transport bus for rsfq_jtl_pipe: toggle-encoded inputs/outputs plus
// violation reporting. The harness uses master; the pipe uses slave.
interface rsfq_jtl_pipe_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0] a;
    logic                viol_clr;
    logic [CHANNELS-1:0] q;
    logic                ready;
    logic [CHANNELS-1:0] viol;
    logic [CNT_W-1:0]    drop_cnt;

    modport master (
        output a, viol_clr,
        input  q, ready, viol, drop_cnt
    );

    modport slave (
        input  a, viol_clr,
        output q, ready, viol, drop_cnt
    );
endinterface

// File: rtl/rsfq_jtl_pipe.sv
// Multi-channel clocked JTL model: toggle-encoded pulses cross a fixed-depth
// pipeline. Pulses spaced closer than MIN_GAP are dropped. Inputs are ignored during start-up.
module rsfq_jtl_pipe #(
    parameter int CHANNELS       = 4,
    parameter int DEPTH          = 3,
    parameter int MIN_GAP        = 2,
    parameter int STARTUP_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rsfq_jtl_pipe_if.slave     bus
);
    localparam int SU_W  = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam int SUM_W = CNT_W + $clog2(CHANNELS + 1);

    localparam logic [SU_W-1:0]  SU_END  = SU_W'(STARTUP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [SU_W-1:0]     su_cnt;
    logic                ready;
    logic [CHANNELS-1:0] a_prev;
    logic [CHANNELS-1:0] ev;
    logic [CHANNELS-1:0] acc;
    logic [CHANNELS-1:0] rej;
    logic [GAP_W-1:0]    gap [CHANNELS];
    logic [CHANNELS-1:0] s   [DEPTH];
    logic [CHANNELS-1:0] q_r;
    logic [CHANNELS-1:0] viol_r;
    logic [CNT_W-1:0]    drop_cnt;
    logic [SUM_W-1:0]    drop_sum;

    // With STARTUP_CYCLES=0 the counter resets already at its end value.
    assign ready = (su_cnt == SU_END);

    always_comb begin
        ev       = ready ? (bus.a ^ a_prev) : '0;
        acc      = '0;
        rej      = '0;
        drop_sum = SUM_W'(drop_cnt);
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (ev[i]) begin
                if (gap[i] >= GAP_MAX) acc[i] = 1'b1;
                else                   rej[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            drop_sum = drop_sum + SUM_W'(rej[i]);
        end
        if (drop_sum > CNT_MAX) drop_sum = CNT_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            su_cnt   <= '0;
            a_prev   <= '0;
            viol_r   <= '0;
            drop_cnt <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) gap[i] <= GAP_MAX;
        end else begin
            if (su_cnt != SU_END) su_cnt <= su_cnt + SU_W'(1);
            a_prev   <= bus.a;
            // A rejection on the same edge as viol_clr keeps that channel set.
            viol_r   <= (viol_r & ~{CHANNELS{bus.viol_clr}}) | rej;
            drop_cnt <= drop_sum[CNT_W-1:0];
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (acc[i])                gap[i] <= GAP_W'(1);
                else if (gap[i] < GAP_MAX) gap[i] <= gap[i] + GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) s[k] <= '0;
        end else begin
            s[0] <= acc;
            for (int unsigned k = 1; k < DEPTH; k++) s[k] <= s[k-1];
            q_r <= q_r ^ s[DEPTH-1];
        end
    end

    assign bus.q        = q_r;
    assign bus.ready    = ready;
    assign bus.viol     = viol_r;
    assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_rsfq_jtl_pipe.sv
// Directed bench for rsfq_jtl_pipe: start-up, latency, critical time, clear,
// mid-flight reset (default DUT) and drop-counter saturation (CNT_W=2 DUT).
module tb_rsfq_jtl_pipe;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    rsfq_jtl_pipe_if #(.CHANNELS(4), .CNT_W(8)) bus0 ();
    rsfq_jtl_pipe_if #(.CHANNELS(4), .CNT_W(2)) bus1 ();

    rsfq_jtl_pipe #(
        .CHANNELS(4), .DEPTH(3), .MIN_GAP(2), .STARTUP_CYCLES(8), .CNT_W(8)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    rsfq_jtl_pipe #(
        .CHANNELS(4), .DEPTH(3), .MIN_GAP(2), .STARTUP_CYCLES(8), .CNT_W(2)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs set after step() are sampled at the following rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus0.a        = '0;
        bus0.viol_clr = 1'b0;
        bus1.a        = '0;
        bus1.viol_clr = 1'b0;

        repeat (2) step();
        check("rst_q",     bus0.q,        32'h0);
        check("rst_viol",  bus0.viol,     32'h0);
        check("rst_drop",  bus0.drop_cnt, 32'h0);
        check("rst_ready", bus0.ready,    32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Start-up window: toggles at edges 3 and 6 are ignored.
        step(); step();                 // edges 1,2
        bus0.a[0] = 1'b1;
        step(); step(); step();         // edges 3..5
        bus0.a[0] = 1'b0;
        step(); step();                 // edges 6,7
        check("su_ready7", bus0.ready, 32'h0);
        check("su_q7",     bus0.q,     32'h0);
        step();                         // edge 8
        check("su_ready8", bus0.ready, 32'h1);
        check("su_q8",     bus0.q,     32'h0);
        check("su_viol8",  bus0.viol,  32'h0);

        // Latency: toggle sampled at edge 10 flips q[1] at edge 13.
        step();                         // edge 9
        bus0.a[1] = 1'b1;
        step();                         // edge 10
        check("lat_q10", bus0.q, 32'h0);
        step(); step();                 // edges 11,12
        check("lat_q12", bus0.q, 32'h0);
        step();                         // edge 13
        check("lat_q13", bus0.q, 32'h2);
        step();                         // edge 14
        check("lat_q14", bus0.q, 32'h2);

        // Critical time: edge 15 accepted, 16 dropped, 17 accepted.
        bus0.a[2] = 1'b1;
        step();                         // edge 15
        bus0.a[2] = 1'b0;
        step();                         // edge 16
        check("ct_viol16", bus0.viol,     32'h4);
        check("ct_drop16", bus0.drop_cnt, 32'h1);
        bus0.a[2] = 1'b1;
        step(); step();                 // edges 17,18
        check("ct_q18", bus0.q, 32'h6);
        step();                         // edge 19
        check("ct_q19", bus0.q, 32'h6);
        step();                         // edge 20
        check("ct_q20", bus0.q, 32'h2);

        // Clear, then simultaneous drops on channels 0 and 3.
        bus0.viol_clr = 1'b1;
        step();                         // edge 21
        bus0.viol_clr = 1'b0;
        check("clr_viol21", bus0.viol, 32'h0);
        bus0.a[0] = 1'b1;
        bus0.a[3] = 1'b1;
        step();                         // edge 22
        bus0.a[0] = 1'b0;
        bus0.a[3] = 1'b0;
        step();                         // edge 23
        check("sim_viol23", bus0.viol,     32'h9);
        check("sim_drop23", bus0.drop_cnt, 32'h3);
        step();                         // edge 24
        check("sim_q24", bus0.q, 32'h2);
        step();                         // edge 25
        check("sim_q25", bus0.q, 32'hB);

        // viol_clr coinciding with a new channel-0 rejection.
        bus0.a[0] = 1'b1;
        step();                         // edge 26
        bus0.a[0]     = 1'b0;
        bus0.viol_clr = 1'b1;
        step();                         // edge 27
        bus0.viol_clr = 1'b0;
        check("clrset_viol27", bus0.viol,     32'h1);
        check("clrset_drop27", bus0.drop_cnt, 32'h4);
        step(); step();                 // edges 28,29
        check("clrset_q29", bus0.q, 32'hA);

        // Mid-flight reset: toggle every channel, then reset before emission.
        bus0.a = 4'b1001;
        step();                         // edge 30
        #2;
        rst_n = 1'b0;
        #1;
        check("mf_q_async",  bus0.q,        32'h0);
        check("mf_viol",     bus0.viol,     32'h0);
        check("mf_drop",     bus0.drop_cnt, 32'h0);
        check("mf_ready",    bus0.ready,    32'h0);
        repeat (2) step();
        check("mf_q_held", bus0.q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            check($sformatf("mf_q_e%0d", e),     bus0.q,     32'h0);
            check($sformatf("mf_ready_e%0d", e), bus0.ready, (e == 8) ? 32'h1 : 32'h0);
        end
        repeat (3) step();
        check("mf_q_late", bus0.q, 32'h0);

        // Saturation on the CNT_W=2 instance: five drops hold at 3.
        check("sat_ready", bus1.ready, 32'h1);
        for (int k = 0; k < 4; k++) begin
            bus1.a[1:0] = ~bus1.a[1:0];
            step();
            if (k == 1) check("sat_drop2", bus1.drop_cnt, 32'h2);
            if (k == 3) check("sat_drop4", bus1.drop_cnt, 32'h3);
        end
        bus1.a[2] = 1'b1;
        step();
        bus1.a[2] = 1'b0;
        step();
        check("sat_drop5", bus1.drop_cnt, 32'h3);
        check("sat_viol",  bus1.viol,     32'h7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
